// File: rtl/lenet1_pkg.sv
// Shared constants, stage codes, FSM state encoding and address helpers
// for the LeNet-1 layer sequencer.
package lenet1_pkg;

  localparam int FP_LENGTH      = 16;
  localparam int CONV1_FEATURES = 4;
  localparam int CONV1_KERNEL   = 25;
  localparam int CONV2_FEATURES = 12;
  localparam int CONV2_KERNEL   = 100;
  localparam int FC_OUTPUTS     = 10;
  localparam int FC_INPUTS      = 192;

  localparam int W_ADDR_W = 11;
  localparam int IDX_W    = 4;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] SEL_NONE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_C1   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_P1   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_C2   = 3'd3;
  localparam logic [SEL_W-1:0] SEL_P2   = 3'd4;
  localparam logic [SEL_W-1:0] SEL_FC   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_C1_ISSUE = 4'd1,
    S_C1_WAIT  = 4'd2,
    S_P1_ISSUE = 4'd3,
    S_P1_WAIT  = 4'd4,
    S_C2_ISSUE = 4'd5,
    S_C2_WAIT  = 4'd6,
    S_P2_ISSUE = 4'd7,
    S_P2_WAIT  = 4'd8,
    S_FC_ISSUE = 4'd9,
    S_FC_WAIT  = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  function automatic logic [SEL_W-1:0] stage_of(input state_t s);
    case (s)
      S_C1_ISSUE, S_C1_WAIT: return SEL_C1;
      S_P1_ISSUE, S_P1_WAIT: return SEL_P1;
      S_C2_ISSUE, S_C2_WAIT: return SEL_C2;
      S_P2_ISSUE, S_P2_WAIT: return SEL_P2;
      S_FC_ISSUE, S_FC_WAIT: return SEL_FC;
      default:               return SEL_NONE;
    endcase
  endfunction

  // Kernel strides as shift-add: 25 = 16+8+1, 100 = 64+32+4.
  function automatic logic [W_ADDR_W-1:0] w_base_of(input logic [SEL_W-1:0] sel,
                                                     input logic [IDX_W-1:0] idx);
    logic [W_ADDR_W-1:0] f;
    f = {{(W_ADDR_W-IDX_W){1'b0}}, idx};
    case (sel)
      SEL_C1:  return (f << 4) + (f << 3) + f;
      SEL_C2:  return (f << 6) + (f << 5) + (f << 2);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lenet1_layer_sequencer_fc_argmax.sv
// Signed running argmax over the streamed FC scores; the first score always
// seeds the maximum and ties keep the lower class index.
module fc_argmax
  import lenet1_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        fc_valid,
  input  logic signed [FP_LENGTH-1:0] fc_data,
  output logic [IDX_W-1:0]            count,
  output logic [IDX_W-1:0]            max_idx,
  output logic                        last
);

  logic signed [FP_LENGTH-1:0] max_val;
  logic                        accept;

  assign accept = fc_valid && (count < IDX_W'(FC_OUTPUTS));
  assign last   = accept && (count == IDX_W'(FC_OUTPUTS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      max_idx <= '0;
      max_val <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
      if ((count == '0) || (fc_data > max_val)) begin
        max_val <= fc_data;
        max_idx <= count;
      end
    end
  end

endmodule

// File: rtl/lenet1_layer_sequencer.sv
// LeNet-1 layer sequencer: walks conv1/pool1/conv2/pool2/fc, issuing one
// engine command per step, then scores the FC argmax against the label.
module lenet1_layer_sequencer
  import lenet1_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [FC_OUTPUTS-1:0]       answer,
  output logic                        eng_start,
  output logic [SEL_W-1:0]            eng_sel,
  output logic [IDX_W-1:0]            feat_idx,
  output logic [W_ADDR_W-1:0]         w_base,
  output logic [IDX_W-1:0]            b_idx,
  input  logic                        eng_done,
  input  logic                        fc_valid,
  input  logic signed [FP_LENGTH-1:0] fc_data,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W-1:0]            pred,
  output logic                        result,
  output state_t                      fsm_state
);

  // Engine handshake: eng_start is a one-cycle command pulse in an ISSUE
  // state; eng_done is honoured only in the following WAIT state, so a done
  // coincident with the pulse, or arriving in any other state, is dropped.

  state_t                state, state_next;
  logic [IDX_W-1:0]      feat_q, feat_next;
  logic [W_ADDR_W-1:0]   w_base_q;
  logic [FC_OUTPUTS-1:0] answer_q;
  logic [IDX_W-1:0]      pred_q;
  logic                  result_q;
  logic                  start_accept;
  logic                  fc_take;
  logic [IDX_W-1:0]      fc_count;
  logic [IDX_W-1:0]      max_idx;
  logic                  fc_last;

  assign fc_take = fc_valid && (state == S_FC_WAIT) && (fc_count < IDX_W'(FC_OUTPUTS));

  fc_argmax u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_accept),
    .fc_valid (fc_take),
    .fc_data  (fc_data),
    .count    (fc_count),
    .max_idx  (max_idx),
    .last     (fc_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      feat_q   <= '0;
      w_base_q <= '0;
      answer_q <= '0;
      pred_q   <= '0;
      result_q <= 1'b0;
    end else begin
      state    <= state_next;
      feat_q   <= feat_next;
      w_base_q <= w_base_of(stage_of(state_next), feat_next);
      if (start_accept) begin
        answer_q <= answer;
        pred_q   <= '0;
        result_q <= 1'b0;
      end else if (state == S_DONE) begin
        pred_q   <= max_idx;
        result_q <= answer_q[max_idx];
      end
    end
  end

  always_comb begin
    state_next   = state;
    feat_next    = feat_q;
    start_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          feat_next    = '0;
          state_next   = S_C1_ISSUE;
        end
      end
      S_C1_ISSUE: state_next = S_C1_WAIT;
      S_C1_WAIT: begin
        if (eng_done) begin
          if (feat_q == IDX_W'(CONV1_FEATURES - 1)) begin
            feat_next  = '0;
            state_next = S_P1_ISSUE;
          end else begin
            feat_next  = feat_q + 1'b1;
            state_next = S_C1_ISSUE;
          end
        end
      end
      S_P1_ISSUE: state_next = S_P1_WAIT;
      S_P1_WAIT:  if (eng_done) state_next = S_C2_ISSUE;
      S_C2_ISSUE: state_next = S_C2_WAIT;
      S_C2_WAIT: begin
        if (eng_done) begin
          if (feat_q == IDX_W'(CONV2_FEATURES - 1)) begin
            feat_next  = '0;
            state_next = S_P2_ISSUE;
          end else begin
            feat_next  = feat_q + 1'b1;
            state_next = S_C2_ISSUE;
          end
        end
      end
      S_P2_ISSUE: state_next = S_P2_WAIT;
      S_P2_WAIT:  if (eng_done) state_next = S_FC_ISSUE;
      S_FC_ISSUE: state_next = S_FC_WAIT;
      // FC completes on the tenth score; the engine's own done is not needed.
      S_FC_WAIT:  if (fc_last) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign eng_start = (state == S_C1_ISSUE) || (state == S_P1_ISSUE) ||
                     (state == S_C2_ISSUE) || (state == S_P2_ISSUE) ||
                     (state == S_FC_ISSUE);
  assign eng_sel   = stage_of(state);
  assign feat_idx  = feat_q;
  assign w_base    = w_base_q;
  assign b_idx     = ((eng_sel == SEL_C1) || (eng_sel == SEL_C2)) ? feat_q : '0;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign pred      = done ? max_idx : pred_q;
  assign result    = done ? answer_q[max_idx] : result_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_lenet1_layer_sequencer.sv
// Self-checking bench for lenet1_layer_sequencer: engine model, command and
// result scoreboards, directed runs with hand-computed expectations.
module tb_lenet1_layer_sequencer;
  import lenet1_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [FC_OUTPUTS-1:0]       answer;
  logic                        eng_start;
  logic [SEL_W-1:0]            eng_sel;
  logic [IDX_W-1:0]            feat_idx;
  logic [W_ADDR_W-1:0]         w_base;
  logic [IDX_W-1:0]            b_idx;
  logic                        eng_done;
  logic                        fc_valid;
  logic signed [FP_LENGTH-1:0] fc_data;
  logic                        busy;
  logic                        done;
  logic [IDX_W-1:0]            pred;
  logic                        result;
  state_t                      fsm_state;

  lenet1_layer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .answer    (answer),
    .eng_start (eng_start),
    .eng_sel   (eng_sel),
    .feat_idx  (feat_idx),
    .w_base    (w_base),
    .b_idx     (b_idx),
    .eng_done  (eng_done),
    .fc_valid  (fc_valid),
    .fc_data   (fc_data),
    .busy      (busy),
    .done      (done),
    .pred      (pred),
    .result    (result),
    .fsm_state (fsm_state)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [21:0] exp_cmd_q[$];
  logic [4:0]  exp_res_q[$];
  int n_pass = 0;
  int n_total = 0;
  int starts_seen = 0;
  int done_cnt = 0;
  int run_base = 0;
  int prev_cyc = 0;
  bit chk_gap = 1'b0;

  // engine model configuration
  int  lat = 3;
  int  n_scores = 10;
  bit  spur_done = 1'b0;
  bit  spur_fc = 1'b0;
  int  tenth_cyc = 0;
  logic signed [FP_LENGTH-1:0] score_tab [11];

  int tab_nom[11]  = '{-5, 2, 9, 1, 0, -1, 3, 4, 8, 7, 0};
  int tab_tie[11]  = '{-3, -3, -3, -3, 6, -3, -3, 6, -3, -3, 0};
  int tab_neg[11]  = '{-7, -2, -9, -2, -30, -8, -4, -3, -2, -5, 50};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  task automatic load_scores(input int tab[11], input int n);
    for (int i = 0; i < 11; i++) score_tab[i] = 16'(tab[i]);
    n_scores = n;
  endtask

  task automatic push_cmds();
    for (int f = 0; f < 4; f++) exp_cmd_q.push_back({3'd1, 4'(f), 11'(f * 25), 4'(f)});
    exp_cmd_q.push_back({3'd2, 4'd0, 11'd0, 4'd0});
    for (int f = 0; f < 12; f++) exp_cmd_q.push_back({3'd3, 4'(f), 11'(f * 100), 4'(f)});
    exp_cmd_q.push_back({3'd4, 4'd0, 11'd0, 4'd0});
    exp_cmd_q.push_back({3'd5, 4'd0, 11'd0, 4'd0});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_eng_start"}, 32'(eng_start), 0);
    check({tag, "_eng_sel"},   32'(eng_sel), 0);
    check({tag, "_feat_idx"},  32'(feat_idx), 0);
    check({tag, "_w_base"},    32'(w_base), 0);
    check({tag, "_b_idx"},     32'(b_idx), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_pred"},      32'(pred), 0);
    check({tag, "_result"},    32'(result), 0);
  endtask

  task automatic begin_run(input logic [9:0] ans);
    run_base = starts_seen;
    @(negedge clk);
    start  = 1'b1;
    answer = ans;
    @(negedge clk);
    start  = 1'b0;
    answer = '0;
    check("busy_after_start", 32'(busy), 1);
    check("first_eng_start", 32'(eng_start), 1);
    check("pred_cleared", 32'(pred), 0);
    check("result_cleared", 32'(result), 0);
  endtask

  task automatic run(input logic [9:0] ans, input int exp_pred, input bit exp_res,
                     input bit busy_poke);
    int d0;
    push_cmds();
    exp_res_q.push_back({4'(exp_pred), exp_res});
    d0 = done_cnt;
    begin_run(ans);
    if (busy_poke) begin
      repeat (20) @(negedge clk);
      start  = 1'b1;
      answer = 10'b0000000001;
      @(negedge clk);
      start  = 1'b0;
      answer = '0;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (15) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("eng_start_count", 32'(starts_seen - run_base), 19);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 0);
    check("pred_hold", 32'(pred), 32'(exp_pred));
    check("result_hold", 32'(result), 32'(exp_res));
    exp_cmd_q.delete();
    exp_res_q.delete();
  endtask

  // engine model: eng_done lat cycles after eng_start; FC streams scores instead
  initial begin
    int  countdown;
    bit  fc_pending;
    bit  streaming;
    int  stream_k;
    countdown = 0; fc_pending = 0; streaming = 0; stream_k = 0;
    eng_done = 1'b0; fc_valid = 1'b0; fc_data = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      fc_valid = 1'b0;
      fc_data  = '0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          if (fc_pending) begin
            streaming = 1'b1;
            stream_k  = 0;
          end else begin
            eng_done = 1'b1;
          end
        end
      end
      if (streaming) begin
        if (stream_k < n_scores) begin
          fc_valid = 1'b1;
          fc_data  = score_tab[stream_k];
          if (stream_k == 9) tenth_cyc = cyc;
          stream_k++;
        end else begin
          streaming = 1'b0;
        end
      end
      if (eng_start && !rst) begin
        countdown  = lat;
        fc_pending = (eng_sel == SEL_FC);
        if (spur_done) eng_done = 1'b1;
        if (spur_fc && eng_sel == SEL_C2) begin
          fc_valid = 1'b1;
          fc_data  = 16'sd1000;
        end
      end
    end
  end

  // monitor: pops expected commands on eng_start and expected results on done
  initial begin
    logic [21:0] exp_cmd;
    logic [4:0]  exp_res;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        starts_seen++;
        check("cmd_expected", 32'(exp_cmd_q.size() > 0), 1);
        if (exp_cmd_q.size() > 0) begin
          exp_cmd = exp_cmd_q.pop_front();
          check("cmd_sel_feat_wbase_bidx", 32'({eng_sel, feat_idx, w_base, b_idx}), 32'(exp_cmd));
        end
        if (chk_gap && (starts_seen - run_base) > 1) check("cmd_gap", 32'(cyc - prev_cyc), 2);
        prev_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("result_expected", 32'(exp_res_q.size() > 0), 1);
        if (exp_res_q.size() > 0) begin
          exp_res = exp_res_q.pop_front();
          check("pred_result_at_done", 32'({pred, result}), 32'(exp_res));
        end
        check("busy_low_at_done", 32'(busy), 0);
        check("done_latency", 32'(cyc), 32'(tenth_cyc + 1));
      end
    end
  end

  // directed sequence
  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    answer = '0;
    load_scores(tab_nom, 10);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal: argmax 9 at class 2
    lat = 3;
    run(10'b0000000100, 2, 1'b1, 1'b0);

    // ties and negatives, zero-latency engine
    lat = 1;
    chk_gap = 1'b1;
    load_scores(tab_tie, 10);
    run(10'b0010000000, 4, 1'b0, 1'b0);
    chk_gap = 1'b0;

    // spurious eng_done, fc_valid in C2, start while busy
    lat = 3;
    spur_done = 1'b1;
    spur_fc = 1'b1;
    load_scores(tab_nom, 10);
    run(10'b0000000100, 2, 1'b1, 1'b1);
    spur_done = 1'b0;
    spur_fc = 1'b0;

    // reset in the middle of conv2 feature 5, late eng_done follows
    push_cmds();
    begin_run(10'b0000000100);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (eng_start && eng_sel == SEL_C2 && feat_idx == 4'd5) found = 1'b1;
    end
    check("reached_c2_feat5", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cmd_q.delete();
    repeat (8) @(negedge clk);
    check_all_zero("after_abort");
    check("idle_after_abort", 32'(fsm_state), 32'(S_IDLE));

    // restart from conv1 feature 0, 11 score strobes, negative tie at class 1
    load_scores(tab_neg, 11);
    run(10'b0000000010, 1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lenet1_layer_sequencer.md
# lenet1_layer_sequencer

Top-level sequencer for the LeNet-1 inference datapath. On `start` it runs one image through conv1 (4 feature maps), pool1+ReLU, conv2 (12 feature maps), pool2+ReLU and the fully connected layer. It issues one engine command per step with a start/done handshake and supplies the weight/bias memory base addresses for each command. It then takes the 10 streamed FC scores, picks the predicted class (argmax) and compares it against the one-hot `answer` to produce `result`.

## Interface
- `FP_LENGTH`, 16, fixed-point word width (signed two's complement)
- `CONV1_FEATURES`, 4, conv1 feature maps
- `CONV1_KERNEL`, 25, weights per conv1 feature (5x5)
- `CONV2_FEATURES`, 12, conv2 feature maps
- `CONV2_KERNEL`, 100, weights per conv2 feature
- `FC_OUTPUTS`, 10, FC scores / classes
- `FC_INPUTS`, 192, weights per FC output

Clock is `clk`; reset is `rst`. One clock; reset is synchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `start` in 1: begin one inference; sampled only in IDLE
- `answer` in 10: one-hot label, bit k = class k; sampled on accepted `start`
- `eng_start` out 1: one-cycle command pulse to the datapath
- `eng_sel` out 3: stage code; valid while `eng_start` is high
- `feat_idx` out 4: feature/output index within the stage
- `w_base` out 11: weight memory base index for this command
- `b_idx` out 4: bias memory index for this command
- `eng_done` in 1: datapath finished the outstanding command (1-cycle pulse)
- `fc_valid` in 1: FC score strobe
- `fc_data` in FP_LENGTH: signed FC score; scores arrive in class order 0..9
- `busy` out 1: high from accepted `start` until `done`
- `done` out 1: one-cycle pulse; `result` and `pred` are valid from this cycle
- `pred` out 4: argmax class
- `result` out 1: 1 when `answer[pred]` is set

## Operation
- States: IDLE, C1, P1, C2, P2, FC, DONE. Each engine state has ISSUE and WAIT sub-phases.
- Stage codes: C1=1, P1=2, C2=3, P2=4, FC=5. `eng_sel` is 0 when idle.
- IDLE: when `start`=1, latch `answer`, set `busy`, clear the argmax state, go to C1 ISSUE with `feat_idx`=0.
- ISSUE: pulse `eng_start` for one cycle, then go to WAIT. WAIT: on `eng_done`, increment `feat_idx` or advance to the next stage.
- C1 addressing: `w_base`=`feat_idx`*25, `b_idx`=`feat_idx`. Loop over features 0..3.
- C2 addressing: `w_base`=`feat_idx`*100, `b_idx`=`feat_idx`. Loop over features 0..11.
- P1 and P2 issue one command each. For these, `w_base`=0, `b_idx`=0, `feat_idx`=0.
- FC issues one command with `w_base`=0 and `b_idx`=0. The FC weight row for output k is k*192; the engine adds this offset itself.
- In FC WAIT the sequencer counts `fc_valid` strobes (k=0..9) and keeps the running maximum:
  - Signed compare.
  - Strictly greater replaces the maximum, so on a tie the lower index wins.
  - Score 0 always initialises the maximum.
- After the 10th score, the sequencer does not wait for `eng_done`. It goes to DONE, pulses `done`, drives `pred` and `result`, clears `busy`, and returns to IDLE.
- Ignored inputs:
  - `eng_done` in the same cycle as `eng_start`, or outside a WAIT phase.
  - `fc_valid` outside FC WAIT, or after the 10th score.
  - `start` while `busy`.
- `eng_done` in FC WAIT is ignored; completion of FC is defined by the 10 scores.
- `answer` that is not one-hot: `result`=`answer[pred]`, no checking.
- `rst` at any time, including mid-stage, returns the block to IDLE. All outputs return to 0 and the counters and maximum are cleared. A late `eng_done` from an aborted command is ignored.

## Timing
- Reset values: `eng_start`, `eng_sel`, `feat_idx`, `w_base`, `b_idx`, `busy`, `done`, `pred` and `result` are all 0.
- `start` sampled at cycle 0: `busy`=1 and the first `eng_start` are at cycle 1.
- `eng_done` at cycle t: the next `eng_start` is at cycle t+1.
- 10th `fc_valid` at cycle t: `done`=1 at t+1 with final `pred`/`result`; `busy`=0 at t+1.
- `pred`/`result` hold until the next accepted `start`, which clears them to 0.
- Each inference issues exactly 19 `eng_start` pulses: 4 + 1 + 12 + 1 + 1.
- `w_base` is computed as a registered multiply by a constant (shift-add), so it is stable in the cycle of `eng_start`.

## Structure
- Shared package `lenet1_pkg`:
  - FP_LENGTH and the layer-count and kernel-size constants.
  - Stage-code localparams.
  - The state enum.
  - Address widths (`W_ADDR_W`=11, `IDX_W`=4).
- Sub-module `fc_argmax`:
  - Inputs: `clk`, `rst`, `clear`, `fc_valid`, `fc_data`.
  - Outputs: `count`, `max_idx`, `last`.
  - Behaviour: signed running maximum with lower index winning ties.
- The top-level FSM instantiates `fc_argmax` and performs the `answer` compare.

## Test plan
- Nominal run: engine model returns `eng_done` 3 cycles after each `eng_start`; scores are [−5,2,9,1,0,−1,3,4,8,7]; `answer`=10'b0000000100. Expect:
  - 19 pulses with the correct `eng_sel`/`feat_idx`.
  - C1 `w_base` sequence 0,25,50,75; C2 `w_base` sequence 0,100,…,1100.
  - `pred`=2, `result`=1, `done` one cycle after the 10th score.
- Tie and negatives: all scores −3 except class 4 and class 7, both +6 → `pred`=4. With `answer`=one-hot 7 → `result`=0.
- Spurious inputs: `eng_done` in the same cycle as `eng_start`, `fc_valid` during C2, and `start` while busy → all ignored. The `eng_start` count stays 19 and the result is unchanged.
- Zero-latency engine: `eng_done` the cycle after every `eng_start` → back-to-back commands every 2 cycles, no skipped features.
- Reset mid-C2 (`feat_idx`=5), then a late `eng_done` → all outputs 0, stays in IDLE. A new `start` restarts at C1 `feat_idx`=0.
- 11 `fc_valid` strobes → the 11th is ignored, `done` pulses exactly once.
